// File: rtl/pipe_pkg.sv
// Shared types and per-stage kill constants for the elastic pipeline stage register.
// Optional feature macro used by pipe_stage_reg: PIPE_SKID_EN (adds a 1-entry skid buffer).
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int CTRL_W_DEFAULT = 16;

  // Control value presented for a killed/bubble entry at each stage boundary.
  // ID/EX kills with the MemWrite byte mask (bits [5:2]) forced to all ones.
  localparam logic [CTRL_W_DEFAULT-1:0] IF_ID_CTRL_KILL  = 16'h0000;
  localparam logic [CTRL_W_DEFAULT-1:0] ID_EX_CTRL_KILL  = 16'h003C;
  localparam logic [CTRL_W_DEFAULT-1:0] EX_MEM_CTRL_KILL = 16'h0000;
  localparam logic [CTRL_W_DEFAULT-1:0] MEM_WB_CTRL_KILL = 16'h0000;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry holding register (payload + control + valid) used as the skid slot
// of pipe_stage_reg when PIPE_SKID_EN is defined.
module pipe_skid_buf #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic [CTRL_W-1:0] push_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Occupancy flag: clear (flush) wins over push, push wins over pop.
  always_ff @(posedge clk) begin
    if (reset || clear) valid <= 1'b0;
    else if (push)      valid <= 1'b1;
    else if (pop)       valid <= 1'b0;
  end

  // Parked entry contents, captured only on push.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      ctrl <= '0;
    end else if (push) begin
      data <= push_data;
      ctrl <= push_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake, flush and bubble insertion.
// Optional feature macro: PIPE_SKID_EN -- adds a 1-entry skid buffer so in_ready is
// registered (no combinational path from out_ready).
//
// Handshake: an entry moves across a port on a clock edge where both valid and ready
// are high; valid never depends on ready of the same port, payload is held stable
// while valid=1 and ready=0, and out_ctrl equals CTRL_KILL whenever out_valid=0.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                CTRL_W    = 16,
  parameter logic [CTRL_W-1:0] CTRL_KILL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        state
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CTRL_W-1:0] enter_ctrl;
  logic              slot_free;
  logic              enter;

  assign out_valid  = (state_q != ST_EMPTY);
  assign out_data   = data_q;
  assign out_ctrl   = ctrl_q;
  assign state      = state_q;

  // A bubble is an entry whose control is replaced wholesale by CTRL_KILL.
  assign enter_ctrl = bubble ? CTRL_KILL : in_ctrl;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic              skid_push;
  logic              skid_pop;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (skid_push),
    .pop       (skid_pop),
    .push_data (in_data),
    .push_ctrl (enter_ctrl),
    .valid     (skid_valid),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );

  // Space exists whenever the skid slot is empty; independent of out_ready.
  assign slot_free = !skid_valid;
`else
  // Space exists if main is empty or is being drained this cycle.
  assign slot_free = !out_valid || out_ready;
`endif

  // Bubble holds off upstream so its entry loads on the following cycle.
  assign in_ready = slot_free && !bubble;
  // Something enters the stage this edge: a bubble, or an accepted input.
  assign enter    = slot_free && !flush && (bubble || in_valid);

  // Next-state and next main-register contents; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    ctrl_d    = ctrl_q;
`ifdef PIPE_SKID_EN
    skid_push = 1'b0;
    skid_pop  = 1'b0;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
      ctrl_d  = CTRL_KILL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (enter) begin
            state_d = ST_FULL;
            data_d  = in_data;
            ctrl_d  = enter_ctrl;
          end
        end
        ST_FULL: begin
          if (enter) begin
`ifdef PIPE_SKID_EN
            if (out_ready) begin
              data_d = in_data;
              ctrl_d = enter_ctrl;
            end else begin
              skid_push = 1'b1;
              state_d   = ST_SKID;
            end
`else
            data_d = in_data;
            ctrl_d = enter_ctrl;
`endif
          end else if (out_ready) begin
            state_d = ST_EMPTY;
            ctrl_d  = CTRL_KILL;
          end
        end
`ifdef PIPE_SKID_EN
        ST_SKID: begin
          if (out_ready) begin
            data_d   = skid_data;
            ctrl_d   = skid_ctrl;
            skid_pop = 1'b1;
            state_d  = ST_FULL;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
          ctrl_d  = CTRL_KILL;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Main payload/control register.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      ctrl_q <= CTRL_KILL;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

endmodule
